// File: rtl/dds_wr_arbiter_pkg.sv
// dds_wr_arbiter shared types and constants.
// Arbiter FSM states, bus widths and default watchdog limit.
package dds_arb_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TMO_W   = 16;
  localparam int TMO_DEF = 65535;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    UPD,
    FIN
  } state_t;

endpackage

// File: rtl/dds_wr_arbiter_if.sv
// Serial register-write engine bus.
// master = arbiter side, slave = engine side.
interface dds_wr_arbiter_if;
  import dds_arb_pkg::*;

  logic              wr_start;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_din;
  logic [DATA_W-1:0] wr_dout;
  logic              wr_done;

  modport master (
    output wr_start,
    output wr_addr,
    output wr_din,
    input  wr_dout,
    input  wr_done
  );

  modport slave (
    input  wr_start,
    input  wr_addr,
    input  wr_din,
    output wr_dout,
    output wr_done
  );

endinterface

// File: rtl/dds_wr_arbiter_rr_pick.sv
// Combinational N-way round-robin picker.
// Search starts at the index after last_gnt and wraps.
module rr_pick #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_gnt,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IW = $clog2(N_REQ);

  logic        found;
  logic [IW:0] s;

  // first requester at or after last_gnt+1 (mod N_REQ) wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    s     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      s = {1'b0, last_gnt} + (IW+1)'(k);
      if (s >= (IW+1)'(N_REQ))
        s = s - (IW+1)'(N_REQ);
      if (!found && req[s[IW-1:0]]) begin
        found          = 1'b1;
        gnt[s[IW-1:0]] = 1'b1;
        idx            = s[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/dds_wr_arbiter.sv
// Round-robin arbiter sharing one DDS serial write engine.
// Latches winner request, runs one transaction, optional IO_UPDATE.
module dds_wr_arbiter
  import dds_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int IOUP_W = 4,
  parameter int TMO    = TMO_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [ADDR_W*N_REQ-1:0]  req_addr,
  input  logic [DATA_W*N_REQ-1:0]  req_din,
  input  logic [N_REQ-1:0]         req_upd,
  output logic [N_REQ-1:0]         done,
  output logic                     err,
  output logic [DATA_W-1:0]        rd_data,
  output logic [N_REQ-1:0]         gnt,
  dds_wr_arbiter_if.master         wr,
  output logic                     IO_UPDATE
);

  localparam int IW = $clog2(N_REQ);

  state_t            state;
  state_t            state_nx;
  logic [IW-1:0]     last_gnt;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     pick_idx;
  logic [N_REQ-1:0]  pick_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  logic              sel_upd;
  logic              upd_r;
  logic              err_r;
  logic              done_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [15:0]       upd_cnt;
  logic              edge_hit;
  logic              tmo_hit;
  logic              upd_last;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req      (req),
    .last_gnt (last_gnt),
    .gnt      (pick_gnt),
    .idx      (pick_idx)
  );

  assign edge_hit = wr.wr_done & ~done_q;
  assign tmo_hit  = (tmo_cnt == TMO_W'(TMO));
  assign upd_last = (upd_cnt == 16'(IOUP_W - 1));

  // mux the winner's request fields out of the flat buses
  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_upd  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_din  = req_din[i*DATA_W +: DATA_W];
        sel_upd  = req_upd[i];
      end
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // next-state decode; a done edge beats a same-cycle timeout
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (|req) state_nx = START;
      START:   state_nx = WAIT;
      WAIT: begin
        if (edge_hit)
          state_nx = upd_r ? UPD : FIN;
        else if (tmo_hit)
          state_nx = FIN;
      end
      UPD:     if (upd_last) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state-decoded strobes
  always_comb begin
    wr.wr_start = (state == START);
    IO_UPDATE   = (state == UPD);
    done        = (state == FIN) ? gnt : '0;
    err         = (state == FIN) & err_r;
  end

  // grant, latched request, counters, edge detect, read-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= '0;
      win_idx    <= '0;
      last_gnt   <= IW'(N_REQ - 1);
      wr.wr_addr <= '0;
      wr.wr_din  <= '0;
      rd_data    <= '0;
      upd_r      <= 1'b0;
      err_r      <= 1'b0;
      done_q     <= 1'b0;
      tmo_cnt    <= '0;
      upd_cnt    <= '0;
    end else begin
      done_q <= wr.wr_done;
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt        <= pick_gnt;
            win_idx    <= pick_idx;
            wr.wr_addr <= sel_addr;
            wr.wr_din  <= sel_din;
            upd_r      <= sel_upd;
            err_r      <= 1'b0;
          end
        end
        START: begin
          tmo_cnt <= '0;
          upd_cnt <= '0;
        end
        WAIT: begin
          if (!tmo_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
          if (edge_hit)
            rd_data <= wr.wr_dout;
          else if (tmo_hit)
            err_r <= 1'b1;
        end
        UPD: begin
          upd_cnt <= upd_cnt + 16'd1;
        end
        FIN: begin
          last_gnt <= win_idx;
          gnt      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_wr_arbiter.sv
// Directed bench for dds_wr_arbiter.
// N_REQ=2, IOUP_W=4, TMO=100; engine played by the stimulus.
module tb_dds_wr_arbiter;
  import dds_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] req_addr;
  logic [63:0] req_din;
  logic [1:0]  req_upd;
  logic [1:0]  done;
  logic        err;
  logic [31:0] rd_data;
  logic [1:0]  gnt;
  logic        IO_UPDATE;

  int ntests = 0;
  int nfail  = 0;

  dds_wr_arbiter_if wr_bus ();

  dds_wr_arbiter #(
    .N_REQ  (2),
    .IOUP_W (4),
    .TMO    (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_din   (req_din),
    .req_upd   (req_upd),
    .done      (done),
    .err       (err),
    .rd_data   (rd_data),
    .gnt       (gnt),
    .wr        (wr_bus),
    .IO_UPDATE (IO_UPDATE)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (wr_bus.wr_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, wr_bus.wr_start}, 32'd1);
  endtask

  task automatic txn(input string tag,
                     input logic [1:0]  g,
                     input logic [7:0]  a,
                     input logic [31:0] d,
                     input logic [31:0] dout);
    wait_start({tag, "_start"});
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_addr"}, 32'(wr_bus.wr_addr), 32'(a));
    chk({tag, "_din"}, wr_bus.wr_din, d);
    tick();
    tick();
    wr_bus.wr_done = 1'b1;
    wr_bus.wr_dout = dout;
    tick();
    chk({tag, "_done"}, 32'(done), 32'(g));
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rd"}, rd_data, dout);
    wr_bus.wr_done = 1'b0;
  endtask

  initial begin
    int cnt;
    int bad;
    rst            = 1'b1;
    req            = '0;
    req_addr       = '0;
    req_din        = '0;
    req_upd        = '0;
    wr_bus.wr_done = 1'b0;
    wr_bus.wr_dout = '0;
    tick();
    tick();

    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_start", 32'(wr_bus.wr_start), 32'd0);
    chk("rst_ioup", 32'(IO_UPDATE), 32'd0);
    chk("rst_addr", 32'(wr_bus.wr_addr), 32'd0);
    chk("rst_din", wr_bus.wr_din, 32'd0);
    chk("rst_rd", rd_data, 32'd0);

    rst = 1'b0;
    tick();
    chk("idle_gnt", 32'(gnt), 32'd0);

    // single write, engine done 40 cycles after wr_start
    req_addr[7:0]  = 8'h0E;
    req_din[31:0]  = 32'h1234_5678;
    req            = 2'b01;
    tick();
    chk("sw_gnt", 32'(gnt), 32'd1);
    chk("sw_start", 32'(wr_bus.wr_start), 32'd1);
    chk("sw_addr", 32'(wr_bus.wr_addr), 32'h0E);
    chk("sw_din", wr_bus.wr_din, 32'h1234_5678);
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cnt += int'(wr_bus.wr_start);
      bad += int'(done != 2'b00);
    end
    chk("sw_one_start", 32'(cnt), 32'd0);
    chk("sw_early_done", 32'(bad), 32'd0);
    wr_bus.wr_done = 1'b1;
    wr_bus.wr_dout = 32'hA5A5_A5A5;
    tick();
    chk("sw_done", 32'(done), 32'd1);
    chk("sw_err", 32'(err), 32'd0);
    chk("sw_rd", rd_data, 32'hA5A5_A5A5);
    req            = 2'b00;
    wr_bus.wr_done = 1'b0;
    tick();
    chk("sw_done_1cyc", 32'(done), 32'd0);
    chk("sw_gnt_clr", 32'(gnt), 32'd0);

    // IO_UPDATE after transaction
    req_upd = 2'b01;
    req     = 2'b01;
    tick();
    chk("up_start", 32'(wr_bus.wr_start), 32'd1);
    tick();
    tick();
    tick();
    wr_bus.wr_done = 1'b1;
    wr_bus.wr_dout = 32'h5A5A_5A5A;
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      wr_bus.wr_done = 1'b0;
      cnt += int'(IO_UPDATE);
      bad += int'(done != 2'b00);
    end
    chk("up_ioup_w", 32'(cnt), 32'd4);
    chk("up_no_early_done", 32'(bad), 32'd0);
    tick();
    chk("up_ioup_off", 32'(IO_UPDATE), 32'd0);
    chk("up_done", 32'(done), 32'd1);
    chk("up_rd", rd_data, 32'h5A5A_5A5A);
    req     = 2'b00;
    req_upd = 2'b00;
    tick();

    // timeout on requester 1
    req_addr[15:8] = 8'h21;
    req_din[63:32] = 32'h2222_2222;
    req            = 2'b10;
    tick();
    chk("to_gnt", 32'(gnt), 32'd2);
    chk("to_start", 32'(wr_bus.wr_start), 32'd1);
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 101; i++) begin
      tick();
      cnt += int'(IO_UPDATE);
      bad += int'(done != 2'b00);
    end
    chk("to_no_early_done", 32'(bad), 32'd0);
    chk("to_no_ioup", 32'(cnt), 32'd0);
    tick();
    chk("to_done", 32'(done), 32'd2);
    chk("to_err", 32'(err), 32'd1);
    chk("to_rd_keep", rd_data, 32'h5A5A_5A5A);
    chk("to_ioup", 32'(IO_UPDATE), 32'd0);
    req = 2'b00;
    tick();
    chk("to_err_1cyc", 32'(err), 32'd0);

    req = 2'b01;
    txn("to_next", 2'b01, 8'h0E, 32'h1234_5678, 32'hC3C3_C3C3);
    req = 2'b00;
    tick();

    // late request from 1 while 0 waits
    req = 2'b01;
    wait_start("late_s0");
    tick();
    req = 2'b11;
    tick();
    wr_bus.wr_done = 1'b1;
    wr_bus.wr_dout = 32'h1111_2222;
    tick();
    chk("late_done0", 32'(done), 32'd1);
    req            = 2'b10;
    wr_bus.wr_done = 1'b0;
    tick();
    chk("late_idle_done", 32'(done), 32'd0);
    chk("late_idle_gnt", 32'(gnt), 32'd0);
    tick();
    chk("late_gnt1", 32'(gnt), 32'd2);
    chk("late_start1", 32'(wr_bus.wr_start), 32'd1);
    chk("late_addr1", 32'(wr_bus.wr_addr), 32'h21);
    chk("late_din1", wr_bus.wr_din, 32'h2222_2222);
    tick();
    tick();
    wr_bus.wr_done = 1'b1;
    wr_bus.wr_dout = 32'h3333_4444;
    tick();
    chk("late_done1", 32'(done), 32'd2);
    chk("late_rd1", rd_data, 32'h3333_4444);
    req            = 2'b00;
    wr_bus.wr_done = 1'b0;
    tick();
    chk("late_no_dup", 32'(done), 32'd0);

    // reset during WAIT
    req = 2'b01;
    wait_start("mr_start");
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mr_gnt", 32'(gnt), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_start0", 32'(wr_bus.wr_start), 32'd0);
    chk("mr_addr", 32'(wr_bus.wr_addr), 32'd0);
    chk("mr_din", wr_bus.wr_din, 32'd0);
    chk("mr_rd", rd_data, 32'd0);
    chk("mr_err", 32'(err), 32'd0);
    chk("mr_ioup", 32'(IO_UPDATE), 32'd0);
    req_addr = {8'h21, 8'h10};
    req_din  = {32'h2222_2222, 32'h1010_1010};
    req      = 2'b11;
    tick();
    chk("mr_hold_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;

    // round-robin with both requesting continuously
    txn("rr0", 2'b01, 8'h10, 32'h1010_1010, 32'hAAAA_0001);
    txn("rr1", 2'b10, 8'h21, 32'h2222_2222, 32'hAAAA_0002);
    txn("rr2", 2'b01, 8'h10, 32'h1010_1010, 32'hAAAA_0003);
    txn("rr3", 2'b10, 8'h21, 32'h2222_2222, 32'hAAAA_0004);
    req = 2'b00;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
